// File: rtl/conv3x3_mac.sv
// conv3x3_mac: streaming 3x3 convolution multiply-accumulate.
// Pixel columns enter through a 3-column sliding window. Each complete window
// produces one signed dot product against a 9-entry weight table, two cycles
// after the column that completed it. Weights are loaded in the LOAD state,
// and columns are accepted only in RUN.
module conv3x3_mac #(
    parameter int WIDTH     = 8,
    parameter int ACC_WIDTH = 20
) (
    input  logic                        i_clk,
    input  logic                        i_rst,
    input  logic                        i_col_valid,
    input  logic [3*WIDTH-1:0]          i_col_data,
    input  logic                        i_row_start,
    input  logic                        i_wgt_wr,
    input  logic [3:0]                  i_wgt_addr,
    input  logic signed [7:0]           i_wgt_data,
    output logic                        o_ready,
    output logic                        o_valid,
    output logic signed [ACC_WIDTH-1:0] o_data
);

    // Unsigned pixel zero-extended to WIDTH+1 bits, times an 8-bit signed weight.
    localparam int PROD_WIDTH = WIDTH + 9;

    typedef enum logic {
        LOAD = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t                        state, state_nxt;
    logic signed [7:0]             weight      [9];
    logic signed [7:0]             weight_snap [9];
    logic [3*WIDTH-1:0]            win         [3];   // win[0] is the oldest column
    logic [1:0]                    cnt, cnt_nxt;
    logic                          wgt_ok, accept, clear_cnt, win_valid, win_q;
    logic signed [PROD_WIDTH-1:0]  prod_nxt    [9];
    logic signed [PROD_WIDTH-1:0]  prod        [9];
    logic                          p1_valid;
    logic signed [ACC_WIDTH-1:0]   sum;

    assign wgt_ok    = i_wgt_wr && (i_wgt_addr <= 4'd8);
    assign o_ready   = (state == RUN);
    assign accept    = i_col_valid && o_ready;
    assign win_valid = accept && (cnt_nxt == 2'd3);

    // State register.
    // NOTE: sequential state uses non-blocking assignments so that every register
    // samples pre-edge values, independent of the order the blocks are evaluated in.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) state <= LOAD;
        else       state <= state_nxt;
    end

    // Next state: a write to the last weight starts RUN, a write to weight 0 returns to LOAD.
    // NOTE: every signal driven here gets a default first, so no path leaves it
    // unassigned and no latch is inferred.
    always_comb begin
        state_nxt = state;
        clear_cnt = 1'b0;
        if (wgt_ok) begin
            if (state == LOAD && i_wgt_addr == 4'd8) begin
                state_nxt = RUN;
            end else if (state == RUN && i_wgt_addr == 4'd0) begin
                state_nxt = LOAD;
                clear_cnt = 1'b1;
            end
        end
    end

    // Column counter: restarts at 1 on a row start and saturates at 3 (window full).
    always_comb begin
        cnt_nxt = cnt;
        if (clear_cnt) begin
            cnt_nxt = 2'd0;
        end else if (accept) begin
            if (i_row_start)       cnt_nxt = 2'd1;
            else if (cnt != 2'd3)  cnt_nxt = cnt + 2'd1;
        end
    end

    // Weight table write port; out-of-range addresses match no entry.
    // NOTE: this small register array is reset explicitly because results after a
    // reset must see all-zero weights; a RAM-style table without reset would not.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            for (int k = 0; k < 9; k++) weight[k] <= '0;
        end else begin
            for (int k = 0; k < 9; k++) begin
                if (wgt_ok && i_wgt_addr == 4'(k)) weight[k] <= i_wgt_data;
            end
        end
    end

    // Window shift and counter. The weights in force at the accept edge are captured
    // with the window, so a write on that same edge only affects later windows.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            cnt   <= 2'd0;
            win_q <= 1'b0;
            for (int c = 0; c < 3; c++) win[c] <= '0;
            for (int k = 0; k < 9; k++) weight_snap[k] <= '0;
        end else begin
            cnt   <= cnt_nxt;
            win_q <= win_valid;
            if (accept) begin
                win[0] <= win[1];
                win[1] <= win[2];
                win[2] <= i_col_data;
            end
            if (win_valid) begin
                for (int k = 0; k < 9; k++) weight_snap[k] <= weight[k];
            end
        end
    end

    // Products: row r of column c is bits [(2-r)*WIDTH +: WIDTH]; top row is most significant.
    always_comb begin
        prod_nxt = '{default: '0};
        for (int r = 0; r < 3; r++) begin
            for (int c = 0; c < 3; c++) begin
                prod_nxt[r*3+c] = PROD_WIDTH'($signed({1'b0, win[c][(2-r)*WIDTH +: WIDTH]}))
                                * PROD_WIDTH'(weight_snap[r*3+c]);
            end
        end
    end

    // Stage 1: register the nine products of a completed window.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            p1_valid <= 1'b0;
            for (int k = 0; k < 9; k++) prod[k] <= '0;
        end else begin
            p1_valid <= win_q;
            if (win_q) begin
                for (int k = 0; k < 9; k++) prod[k] <= prod_nxt[k];
            end
        end
    end

    // Sign-extended sum of the products; the full range fits ACC_WIDTH.
    always_comb begin
        sum = '0;
        for (int k = 0; k < 9; k++) sum = sum + ACC_WIDTH'(prod[k]);
    end

    // Stage 2: publish the result as a one-cycle pulse; o_data holds between results.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            o_valid <= 1'b0;
            o_data  <= '0;
        end else begin
            o_valid <= p1_valid;
            if (p1_valid) o_data <= sum;
        end
    end

endmodule

// File: tb/tb_conv3x3_mac.sv
// Testbench for conv3x3_mac: directed scenarios plus a randomized phase, all
// checked by a scoreboard fed from a row-level reference model.
module tb_conv3x3_mac;

    localparam int  WIDTH     = 8;
    localparam int  ACC_WIDTH = 20;
    localparam time HALF      = 5;
    localparam time PERIOD    = 2 * HALF;

    logic                        clk;
    logic                        rst;
    logic                        col_valid;
    logic [3*WIDTH-1:0]          col_data;
    logic                        row_start;
    logic                        wgt_wr;
    logic [3:0]                  wgt_addr;
    logic signed [7:0]           wgt_data;
    logic                        ready;
    logic                        valid;
    logic signed [ACC_WIDTH-1:0] data;

    conv3x3_mac #(.WIDTH(WIDTH), .ACC_WIDTH(ACC_WIDTH)) dut (
        .i_clk       (clk),
        .i_rst       (rst),
        .i_col_valid (col_valid),
        .i_col_data  (col_data),
        .i_row_start (row_start),
        .i_wgt_wr    (wgt_wr),
        .i_wgt_addr  (wgt_addr),
        .i_wgt_data  (wgt_data),
        .o_ready     (ready),
        .o_valid     (valid),
        .o_data      (data)
    );

    initial clk = 1'b0;
    always #HALF clk = ~clk;

    typedef struct {
        int  value;
        time t;       // clock edge after which o_valid must be high
    } exp_t;

    exp_t              sb[$];
    logic [23:0]       row[$];      // columns of the current image row (newest last)
    logic signed [7:0] m_w [9];
    bit                m_run;
    int                last_data;
    int                pulses;
    int                checks;
    int                failures;
    logic signed [7:0] wv [9];

    task automatic check(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Dot product of the last three columns of the row: weight index row*3+col,
    // row 0 = top pixel (high byte), col 0 = oldest column.
    function automatic int window_dot();
        int s = 0;
        for (int c = 0; c < 3; c++) begin
            logic [23:0] col = row[row.size() - 3 + c];
            for (int r = 0; r < 3; r++) begin
                logic [7:0] pix = col[(2-r)*8 +: 8];
                s += int'(pix) * int'(m_w[r*3+c]);
            end
        end
        return s;
    endfunction

    // Reference model for one clock edge, using the pre-edge model state.
    task automatic model_edge(input logic cv, input logic [23:0] cd, input logic rs,
                              input logic ww, input logic [3:0] wa, input logic [7:0] wd);
        bit leaving = ww && (wa == 4'd0) && m_run;
        if (cv && m_run) begin
            if (rs) row.delete();
            row.push_back(cd);
            if (row.size() > 3) void'(row.pop_front());
            if (!leaving && row.size() == 3) sb.push_back('{window_dot(), $time + 2 * PERIOD});
        end
        if (ww && wa <= 4'd8) begin
            m_w[wa] = wd;
            if (wa == 4'd8 && !m_run) begin
                m_run = 1'b1;
            end else if (leaving) begin
                m_run = 1'b0;
                row.delete();
            end
        end
    endtask

    task automatic step(input logic cv, input logic [23:0] cd, input logic rs,
                        input logic ww, input logic [3:0] wa, input logic [7:0] wd);
        @(negedge clk);
        col_valid = cv;
        col_data  = cd;
        row_start = rs;
        wgt_wr    = ww;
        wgt_addr  = wa;
        wgt_data  = wd;
        @(posedge clk);
        model_edge(cv, cd, rs, ww, wa, wd);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 24'h0, 1'b0, 1'b0, 4'd0, 8'h0);
    endtask

    task automatic col(input logic [23:0] cd, input logic rs);
        step(1'b1, cd, rs, 1'b0, 4'd0, 8'h0);
    endtask

    task automatic write_all();
        for (int i = 0; i < 9; i++) step(1'b0, 24'h0, 1'b0, 1'b1, 4'(i), wv[i]);
    endtask

    task automatic model_reset();
        sb.delete();
        row.delete();
        m_run     = 1'b0;
        last_data = 0;
        for (int i = 0; i < 9; i++) m_w[i] = '0;
    endtask

    // Monitor: every cycle, compare o_valid/o_data/o_ready against the scoreboard.
    always @(negedge clk) begin
        time  edge_t;
        bit   exp_v;
        exp_t e;
        edge_t = $time - HALF;
        while (sb.size() > 0 && sb[0].t < edge_t) begin
            checks++;
            failures++;
            $display("FAIL missing_result: no o_valid, expected data %0d at t=%0t", sb[0].value, sb[0].t);
            void'(sb.pop_front());
        end
        exp_v = (sb.size() > 0) && (sb[0].t == edge_t);
        check("o_valid", longint'(valid), longint'(exp_v));
        if (valid) pulses++;
        if (exp_v) begin
            e = sb.pop_front();
            check("o_data", longint'(data), longint'(e.value));
            last_data = e.value;
        end else begin
            check("o_data_hold", longint'(data), longint'(last_data));
        end
        check("o_ready", longint'(ready), longint'(m_run));
    end

    initial begin
        int p0;
        checks = 0; failures = 0; pulses = 0;
        col_valid = 0; col_data = '0; row_start = 0;
        wgt_wr = 0; wgt_addr = '0; wgt_data = '0;
        model_reset();
        rst = 1'b0;
        #1 rst = 1'b1;
        repeat (2) @(negedge clk);
        check("reset_ready", longint'(ready), 0);
        check("reset_valid", longint'(valid), 0);
        check("reset_data",  longint'(data), 0);
        rst = 1'b0;

        // Columns offered in LOAD are dropped.
        col({8'd10, 8'd10, 8'd10}, 1'b1);
        col({8'd10, 8'd10, 8'd10}, 1'b0);
        col({8'd10, 8'd10, 8'd10}, 1'b0);

        // All weights 1, one 6-column row of 10s: four results of 90.
        for (int i = 0; i < 9; i++) wv[i] = 8'sd1;
        write_all();
        p0 = pulses;
        for (int i = 0; i < 6; i++) col({8'd10, 8'd10, 8'd10}, i == 0);
        idle(3);
        check("ones_pulses", longint'(pulses - p0), 4);
        check("ones_value",  longint'(data), 90);

        // Extreme negative: weights -128, pixels 255.
        for (int i = 0; i < 9; i++) wv[i] = -8'sd128;
        write_all();
        for (int i = 0; i < 3; i++) col({8'd255, 8'd255, 8'd255}, i == 0);
        idle(3);
        check("min_value", longint'(data), -293760);

        // Only the centre weight: result is the middle pixel of the middle column.
        for (int i = 0; i < 9; i++) wv[i] = (i == 4) ? 8'sd1 : 8'sd0;
        write_all();
        col({8'd1, 8'd2, 8'd3}, 1'b1);
        col({8'd4, 8'd5, 8'd6}, 1'b0);
        col({8'd7, 8'd8, 8'd9}, 1'b0);
        idle(3);
        check("centre_value", longint'(data), 5);

        // Row restart after two columns: the first window is all new-row columns.
        for (int i = 0; i < 9; i++) wv[i] = 8'($urandom_range(0, 255));
        write_all();
        p0 = pulses;
        col(24'($urandom), 1'b1);
        col(24'($urandom), 1'b0);
        col(24'($urandom), 1'b1);
        col(24'($urandom), 1'b0);
        col(24'($urandom), 1'b0);
        idle(3);
        check("restart_pulses", longint'(pulses - p0), 1);

        // Three-cycle gaps between columns.
        p0 = pulses;
        for (int i = 0; i < 5; i++) begin
            col(24'($urandom), i == 0);
            idle(3);
        end
        check("gap_pulses", longint'(pulses - p0), 3);

        // Reset while a result sits in stage 1: it is discarded and weights clear.
        col(24'($urandom), 1'b1);
        col(24'($urandom), 1'b0);
        col(24'($urandom), 1'b0);
        idle(1);
        #1 rst = 1'b1;
        model_reset();
        #1;
        check("async_rst_ready", longint'(ready), 0);
        check("async_rst_valid", longint'(valid), 0);
        check("async_rst_data",  longint'(data), 0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        step(1'b0, 24'h0, 1'b0, 1'b1, 4'd8, 8'sd3);
        col(24'h0A0B0C, 1'b1);
        col(24'h0D0E0F, 1'b0);
        col(24'h102030, 1'b0);
        idle(3);
        check("post_rst_value", longint'(data), 48 * 3);

        // Randomized traffic: gaps, row starts, weight writes (some out of range,
        // some on the same edge as an accepted column).
        for (int i = 0; i < 9; i++) wv[i] = 8'($urandom_range(0, 255));
        write_all();
        for (int n = 0; n < 800; n++) begin
            logic       cv = ($urandom_range(0, 9) < 7);
            logic       rs = ($urandom_range(0, 9) == 0);
            logic       ww = ($urandom_range(0, 19) < 3);
            logic [3:0] wa = 4'($urandom_range(0, 15));
            if (ww && wa == 4'd0) cv = 1'b0;
            step(cv, 24'($urandom), rs, ww, wa, 8'($urandom_range(0, 255)));
        end

        for (int i = 0; i < 10 && sb.size() > 0; i++) idle(1);
        idle(2);
        check("drain_empty", longint'(sb.size()), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/conv3x3_mac.md
CONV3X3_MAC -- requirements
Module: conv3x3_mac

Interface
REQ-001 SHALL have parameter WIDTH, default 8, meaning unsigned pixel width.
REQ-002 SHALL have parameter ACC_WIDTH, default 20, meaning signed result width.
REQ-003 SHALL have port i_clk  in  1  sole clock; all state updates on its rising edge.
REQ-004 SHALL have port i_rst  in  1  reset, asynchronous and active-high.
REQ-005 SHALL have port i_col_valid  in  1  column presented this cycle.
REQ-006 SHALL have port i_col_data  in  3*WIDTH  packed pixel column: [23:16] top row, [15:8] middle row, [7:0] bottom row.
REQ-007 SHALL have port i_row_start  in  1  qualifies i_col_valid; the column is the first column of a new image row.
REQ-008 SHALL have port i_wgt_wr  in  1  weight write strobe.
REQ-009 SHALL have port i_wgt_addr  in  4  weight index 0..8, where index = row*3 + col, row 0 = top, col 0 = oldest column.
REQ-010 SHALL have port i_wgt_data  in  8  signed two's-complement weight.
REQ-011 SHALL have port o_ready  out  1  block accepts columns.
REQ-012 SHALL have port o_valid  out  1  o_data holds a new result this cycle (single-cycle pulse per result).
REQ-013 SHALL have port o_data  out  ACC_WIDTH  signed 3x3 dot product.

Function
REQ-014 SHALL implement FSM states LOAD and RUN; o_ready = 1 only in RUN.
REQ-015 SHALL write weight[i_wgt_addr] = i_wgt_data on any edge with i_wgt_wr=1 and addr<=8; addr 9..15 SHALL be ignored with no state change.
REQ-016 LOAD -> RUN SHALL occur on a valid write to addr 8.
REQ-017 RUN -> LOAD SHALL occur on a valid write to addr 0; the same edge SHALL clear the column counter.
REQ-018 A column SHALL be accepted only on an edge where i_col_valid=1 and o_ready=1; columns presented when o_ready=0 SHALL be dropped.
REQ-019 On acceptance, window SHALL shift: col0<=col1, col1<=col2, col2<=i_col_data.
REQ-020 A 2-bit column counter SHALL load 1 on acceptance with i_row_start=1, else increment on acceptance, saturating at 3.
REQ-021 A window SHALL be valid on an acceptance edge where the post-update counter equals 3; rows of C columns SHALL yield C-2 results.
REQ-022 Stage 1 (edge after a valid-window acceptance) SHALL register the 9 products pixel*weight, with pixels zero-extended to 9-bit signed and products 17-bit signed.
REQ-023 Stage 2 (next edge) SHALL register the sign-extended sum of the 9 products into o_data and set o_valid=1; range is +/-293760, so no overflow or saturation is possible at ACC_WIDTH=20.
REQ-024 Latency SHALL be 2 cycles: acceptance at edge N -> o_valid high after edge N+2; the stages SHALL sustain one result per cycle.
REQ-025 o_valid SHALL be 0 in any cycle without a new result; o_data SHALL hold its last value when o_valid=0.
REQ-026 Results already in stage 1 or 2 SHALL complete normally across a RUN -> LOAD transition.
REQ-027 Products already registered SHALL be unaffected by a weight write; a new weight SHALL apply to windows accepted on edges after the write.
REQ-028 Gaps in i_col_valid SHALL hold the window and counter unchanged.
REQ-029 A simultaneous weight write and column accept SHALL use the old weight for that column's products.

Reset
REQ-030 While i_rst=1, state SHALL be LOAD with all weights 0, window 0, counter 0, pipeline valids 0, o_valid=0, o_data=0, o_ready=0.
REQ-031 Assertion of i_rst SHALL take effect immediately, independent of i_clk, discarding in-flight results.

Verification
REQ-032 Write all 9 weights=1, stream one 6-column row of pixels=10 -> exactly 4 o_valid pulses, each o_data=90, the first 2 cycles after the 3rd column.
REQ-033 Weights all -128, pixels all 255 -> o_data = -293760 (20'hB8480).
REQ-034 Only weight[4]=1, columns {1,2,3},{4,5,6},{7,8,9} (top,mid,bot) -> o_data=5.
REQ-035 i_row_start after 2 columns of the previous row -> no result until the 3rd column of the new row; no window mixes rows.
REQ-036 i_col_valid gaps of 3 cycles between columns -> same values as the gap-free run; o_valid per acceptance only; columns with o_ready=0 in LOAD -> ignored.
REQ-037 i_rst pulse while a result is in stage 1 -> o_valid stays 0, o_ready=0, and weights read back 0 in subsequent results.
